// File: rtl/calc_fsm_param.sv
// calc_fsm_param: keypad calculator FSM with BCD operand entry, add/sub/mul and double-dabble result formatting
module calc_fsm_param #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   a_bcd,
  output logic [4*DIGITS-1:0]   b_bcd,
  output logic [8*DIGITS-1:0]   res_bcd,
  output logic [3:0]            operator,
  output logic [2:0]            state,
  output logic                  busy,
  output logic                  done
);
  localparam int RES_BITS = 7*DIGITS;
  localparam int AW = 4*DIGITS;
  localparam int RW = 8*DIGITS;
  localparam int CW = $clog2(RES_BITS);
  typedef enum logic [2:0] {IDLE = 3'd0, ENTER_A = 3'd1, ENTER_B = 3'd2, CALC = 3'd3, CONVERT = 3'd4, SHOW = 3'd5} state_t;
  state_t st, st_n;
  logic [AW-1:0] a_n, b_n, first, a_push, a_pop, b_push, b_pop;
  logic [RW-1:0] res_n, bcd_sr, bcd_n, adj, bcd_sh, fmt, sgn;
  logic [RES_BITS-1:0] bin_sr, bin_n, bin_sh, a_bin, b_bin;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] op_n;
  logic done_n, neg, neg_n, seen;
  logic is_dig, is_op, is_bksp, is_enter, is_clr, a_full, b_full, b_empty;
  function automatic logic [RES_BITS-1:0] to_bin(input logic [AW-1:0] g);
    logic [RES_BITS-1:0] v;
    v = '0;
    for (int i = DIGITS-1; i >= 0; i--)
      v = v*RES_BITS'(10) + RES_BITS'(g[4*i+:4] == 4'hF ? 4'd0 : g[4*i+:4]);
    return v;
  endfunction
  assign state    = st;
  assign busy     = (st == CALC) || (st == CONVERT);
  assign is_dig   = key_code < 4'd10;
  assign is_op    = (key_code >= 4'd10) && (key_code <= 4'd12);
  assign is_clr   = key_code == 4'd13;
  assign is_bksp  = key_code == 4'd14;
  assign is_enter = key_code == 4'd15;
  assign first    = ({AW{1'b1}} << 4) | AW'(key_code);
  // Shifting the inverted value refills the vacated top digit with blank (F)
  assign a_push   = (a_bcd << 4) | AW'(key_code);
  assign a_pop    = ~((~a_bcd) >> 4);
  assign b_push   = (b_bcd << 4) | AW'(key_code);
  assign b_pop    = ~((~b_bcd) >> 4);
  assign a_full   = a_bcd[AW-1-:4] != 4'hF;
  assign b_full   = b_bcd[AW-1-:4] != 4'hF;
  assign b_empty  = &b_bcd;
  assign a_bin    = to_bin(a_bcd);
  assign b_bin    = to_bin(b_bcd);
  assign bcd_sh   = RW'({adj, bin_sr[RES_BITS-1]});
  assign bin_sh   = bin_sr << 1;
  always_comb begin
    adj = bcd_sr;
    for (int i = 0; i < 2*DIGITS; i++)
      adj[4*i+:4] = bcd_sr[4*i+:4] >= 4'd5 ? bcd_sr[4*i+:4] + 4'd3 : bcd_sr[4*i+:4];
  end
  // Blank leading zeros, keep digit 0, then place the minus just above the top digit
  always_comb begin
    seen = 1'b0;
    fmt  = '1;
    for (int i = 2*DIGITS-1; i >= 0; i--) begin
      seen = seen | (bcd_sh[4*i+:4] != 4'd0) | (i == 0);
      fmt[4*i+:4] = seen ? bcd_sh[4*i+:4] : 4'hF;
    end
    sgn = fmt;
    for (int i = 1; i < 2*DIGITS; i++)
      sgn[4*i+:4] = (neg && fmt[4*i+:4] == 4'hF && fmt[4*i-4+:4] != 4'hF) ? 4'hB : fmt[4*i+:4];
  end
  always_comb begin
    st_n   = st;
    a_n    = a_bcd;
    b_n    = b_bcd;
    res_n  = res_bcd;
    op_n   = operator;
    done_n = 1'b0;
    bcd_n  = bcd_sr;
    bin_n  = bin_sr;
    cnt_n  = cnt;
    neg_n  = neg;
    case (st)
      IDLE: if (key_valid && is_dig) begin
        a_n  = first;
        st_n = ENTER_A;
      end
      ENTER_A: if (key_valid) begin
        if (is_dig) a_n = a_full ? a_bcd : a_push;
        else if (is_bksp) begin
          a_n  = a_pop;
          st_n = &a_pop ? IDLE : ENTER_A;
        end else if (is_op) begin
          op_n = key_code;
          st_n = ENTER_B;
        end
      end
      ENTER_B: if (key_valid) begin
        if (is_dig) b_n = b_full ? b_bcd : b_push;
        else if (is_bksp) b_n = b_empty ? b_bcd : b_pop;
        else if (is_op) op_n = b_empty ? key_code : operator;
        else if (is_enter) st_n = b_empty ? ENTER_B : CALC;
      end
      CALC: begin
        bin_n = operator == 4'd10 ? a_bin + b_bin :
                operator == 4'd11 ? (b_bin > a_bin ? b_bin - a_bin : a_bin - b_bin) :
                a_bin * b_bin;
        neg_n = (operator == 4'd11) && (b_bin > a_bin);
        bcd_n = '0;
        cnt_n = '0;
        st_n  = CONVERT;
      end
      CONVERT: begin
        bcd_n = bcd_sh;
        bin_n = bin_sh;
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(RES_BITS-1)) begin
          res_n  = sgn;
          done_n = 1'b1;
          st_n   = SHOW;
        end
      end
      SHOW: if (key_valid && is_dig) begin
        a_n   = first;
        b_n   = '1;
        res_n = '1;
        op_n  = 4'hF;
        st_n  = ENTER_A;
      end
      default: st_n = IDLE;
    endcase
    if (key_valid && is_clr && !busy) begin
      a_n   = '1;
      b_n   = '1;
      res_n = '1;
      op_n  = 4'hF;
      st_n  = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st       <= IDLE;
      a_bcd    <= '1;
      b_bcd    <= '1;
      res_bcd  <= '1;
      operator <= 4'hF;
      done     <= 1'b0;
      bcd_sr   <= '0;
      bin_sr   <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
    end else begin
      st       <= st_n;
      a_bcd    <= a_n;
      b_bcd    <= b_n;
      res_bcd  <= res_n;
      operator <= op_n;
      done     <= done_n;
      bcd_sr   <= bcd_n;
      bin_sr   <= bin_n;
      cnt      <= cnt_n;
      neg      <= neg_n;
    end
endmodule
